// File: rtl/ram_pkg.sv
// ram_pkg: shared sizes and byte-select encoding for the byte-view data memory
package ram_pkg;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic [1:0] {
    BYTE0 = 2'b00,
    BYTE1 = 2'b01,
    BYTE2 = 2'b10,
    BYTE3 = 2'b11
  } byte_sel_t;
endpackage

// File: rtl/byte_sel_mux.sv
// byte_sel_mux: combinational pick of one byte from a 32-bit word (din, sel -> dout)
import ram_pkg::*;
module byte_sel_mux (
  input  logic [31:0] din,
  input  logic [1:0]  sel,
  output logic [7:0]  dout
);
  always_comb dout = sel == BYTE0 ? din[7:0]
                   : sel == BYTE1 ? din[15:8]
                   : sel == BYTE2 ? din[23:16]
                   : din[31:24];
endmodule

// File: rtl/ram_byte_view.sv
// ram_byte_view: 64x32 sync RAM with registered read; LED shows byte MUX of last read (clk, rst, Mem_Addr, Mem_Data_In, Mem_Write, Mem_Read, MUX -> LED); MEM_CLEAR_EN clears one word per reset cycle
module ram_byte_view #(
  parameter int ADDR_W = ram_pkg::ADDR_W,
  parameter int DATA_W = ram_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] Mem_Addr,
  input  logic [DATA_W-1:0] Mem_Data_In,
  input  logic              Mem_Write,
  input  logic              Mem_Read,
  input  logic [1:0]        MUX,
  output logic [7:0]        LED
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata;
`ifdef MEM_CLEAR_EN
  logic [ADDR_W-1:0] clr_cnt;
  // Counter sits at 0 outside reset so every reset walk starts from address 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[clr_cnt] <= '0;
      clr_cnt <= clr_cnt + 1'b1;
    end else begin
      clr_cnt <= '0;
      if (Mem_Write) mem[Mem_Addr] <= Mem_Data_In;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst && Mem_Write) mem[Mem_Addr] <= Mem_Data_In;
  end
`endif
  // A write wins over a simultaneous read; the read register then holds.
  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else if (Mem_Read && !Mem_Write) rdata <= mem[Mem_Addr];
  end
  byte_sel_mux u_mux (
    .din (rdata[31:0]),
    .sel (MUX),
    .dout(LED)
  );
endmodule

// File: tb/tb_ram_byte_view.sv
// tb_ram_byte_view: randomized scoreboard bench for ram_byte_view
module tb_ram_byte_view;
  logic        clk = 0;
  logic        rst;
  logic [5:0]  Mem_Addr;
  logic [31:0] Mem_Data_In;
  logic        Mem_Write;
  logic        Mem_Read;
  logic [1:0]  MUX;
  logic [7:0]  LED;

  always #5 clk = ~clk;

  ram_byte_view dut (
    .clk(clk),
    .rst(rst),
    .Mem_Addr(Mem_Addr),
    .Mem_Data_In(Mem_Data_In),
    .Mem_Write(Mem_Write),
    .Mem_Read(Mem_Read),
    .MUX(MUX),
    .LED(LED)
  );

  logic [31:0] mem_m [64];
  logic [31:0] rd_m;
  bit          rd_known;
  int          rst_run;
  logic [7:0]  exp_q [$];
  int          checks = 0;
  int          errors = 0;

  task automatic cyc(input bit r, input bit w, input bit rd, input logic [5:0] a,
                     input logic [31:0] d, input logic [1:0] m);
    rst = r;
    Mem_Write = w;
    Mem_Read = rd;
    Mem_Addr = a;
    Mem_Data_In = d;
    MUX = m;
    if (rd_known) exp_q.push_back(8'(rd_m >> (8 * int'(m))));
    if (r) begin
      rd_m = 0;
      rd_known = 1;
`ifdef MEM_CLEAR_EN
      if (rst_run < 64) mem_m[rst_run] = 0;
`endif
      rst_run++;
    end else begin
      rst_run = 0;
      if (w) mem_m[a] = d;
      else if (rd) rd_m = mem_m[a];
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #6;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (LED !== e) begin
          errors++;
          $display("FAIL led: got %h expected %h (MUX=%0d) at %0t", LED, e, MUX, $time);
        end
      end
    end
  end

  initial begin
    int nrst;
    rst = 0; Mem_Write = 0; Mem_Read = 0; Mem_Addr = 0; Mem_Data_In = 0; MUX = 0;
    rd_known = 0;
    rst_run = 0;
    @(posedge clk);
    #2;
`ifdef MEM_CLEAR_EN
    nrst = 3;
`else
    nrst = 1;
`endif
    for (int i = 0; i < nrst; i++) cyc(1, 0, 0, 0, 0, 0);
    for (int m = 0; m < 4; m++) cyc(0, 0, 0, 6'(m), 0, 2'(m));
    for (int a = 0; a < 64; a++) cyc(0, 1, 0, 6'(a), $urandom, 2'($urandom_range(0, 3)));
    cyc(0, 1, 0, 0, 32'hA1B2C3D4, 0);
    cyc(0, 0, 1, 0, 0, 0);
    for (int m = 0; m < 4; m++) cyc(0, 0, 0, 0, 0, 2'(m));
    cyc(0, 1, 0, 63, 32'h11223344, 3);
    cyc(0, 1, 0, 1, 32'h55667788, 3);
    cyc(0, 0, 1, 63, 0, 3);
    cyc(0, 0, 1, 1, 0, 3);
    cyc(0, 0, 0, 1, 0, 3);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 5, 32'hDEADBEEF, 1);
    cyc(0, 0, 0, 5, 0, 1);
    cyc(0, 0, 1, 5, 0, 1);
    cyc(0, 0, 0, 5, 0, 1);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 6'($urandom), $urandom, 2'($urandom_range(0, 3)));
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 49) == 0, 1'($urandom), 1'($urandom), 6'($urandom), $urandom,
          2'($urandom_range(0, 3)));
`ifdef MEM_CLEAR_EN
    for (int a = 0; a < 64; a++) cyc(0, 1, 0, 6'(a), $urandom | 32'h1, 0);
    for (int i = 0; i < 64; i++) cyc(1, 1, 1, 6'($urandom), $urandom, 2'($urandom_range(0, 3)));
    for (int a = 0; a < 64; a++) cyc(0, 0, 1, 6'(a), 0, 2'($urandom_range(0, 3)));
`endif
    cyc(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #8;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d pending, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
